comparador_serial: RTL and testbench
====================================

# comparador_serial

Bit-serial counterpart of the team's parallel 3-bit equality/difference comparator. It receives operands A and B one bit per cycle (LSB first) over two serial lines, reassembles them, and reports equality or difference per the latched select. It sits between a serial operand link and the downstream logic that consumes the same 0/1 result convention as the parallel comparator.

## Interface
- WIDTH, 3, operand width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a comparison; sampled only in IDLE
- sel  input  1  0 = test equality, 1 = test difference; latched with start
- bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle
- a_bit  input  1  serial bit of A, LSB first
- b_bit  input  1  serial bit of B, LSB first
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle pulse when resultado is updated
- resultado  output  1  sel=0: 1 if A==B; sel=1: 1 if A!=B; held until next done
- a_word  output  WIDTH  reassembled A
- b_word  output  WIDTH  reassembled B
- bit_count  output  clog2(WIDTH+1)  bits accepted in current comparison

## Operation
- Reset: state IDLE; busy, done, resultado, a_word, b_word, bit_count, internal diff flag and sel_q all 0.
- IDLE: on start=1, latch sel into sel_q, clear diff, bit_count, a_word, b_word; go SHIFT. bit_valid in IDLE is ignored.
- SHIFT: each cycle with bit_valid=1: diff <= diff | (a_bit ^ b_bit); a_bit/b_bit written into a_word/b_word at index bit_count; bit_count increments. Cycles with bit_valid=0 hold all state. On the accepting cycle where bit_count == WIDTH-1, go DONE.
- DONE (one cycle): done=1; resultado <= sel_q ? diff : ~diff; then IDLE.
- start while busy: ignored. sel changes after start: ignored.
- bit_count never exceeds WIDTH; no wrap within a comparison.
- a_word/b_word hold their final value after DONE until the next start.
- rst_n low at any time (mid-SHIFT included): immediate return to reset values; partial comparison discarded, no done pulse.

## Timing
- start in cycle 0 → SHIFT from cycle 1; first bit accepted no earlier than cycle 1.
- With bit_valid continuously high from cycle 1: last bit accepted cycle WIDTH; done and new resultado in cycle WIDTH+1; IDLE in cycle WIDTH+2 (start accepted that cycle).
- resultado, done, busy are registered outputs; no combinational path from inputs to outputs.
- Back-to-back: minimum period between starts is WIDTH+2 cycles.

## Configuration
- COMP_EARLY_EXIT_EN defined: in SHIFT, an accepted bit with a_bit != b_bit moves directly to DONE (result is determined); bit_count, a_word, b_word reflect only bits accepted so far; remaining serial bits from the sender are ignored (IDLE does not consume them).
- Not defined: all WIDTH bits are always consumed; latency is fixed as in Timing.

## Structure
- Shared definitions header: FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), select encodings SEL_IGUAL=0 / SEL_DIFERENTE=1, default WIDTH.
- One natural sub-module: serial_deserializador (bit_count-indexed shift-in of one serial line, instantiated for A and B). FSM and diff accumulation stay in the top.

## Test plan
- Equality, match: sel=0, A=3'b101, B=3'b101, bit_valid held high → done at cycle 4 after start, resultado=1, a_word=b_word=3'b101.
- Difference, mismatch: sel=1, A=3'b001, B=3'b010 → resultado=1; repeat with sel=0 → resultado=0.
- Gapped valid: sel=0, A=B=3'b110, bit_valid pattern 1,0,0,1,0,1 → done exactly one cycle after third valid bit, resultado=1, bit_count=3.
- Reset mid-SHIFT: start, accept 2 bits, pulse rst_n low → no done, all outputs 0; fresh comparison afterward gives correct result.
- start ignored while busy, sel change ignored: toggle sel and pulse start during SHIFT → result uses latched sel, single done pulse.
- With COMP_EARLY_EXIT_EN: sel=1, A=3'b000, B=3'b001 → done one cycle after first bit, resultado=1, bit_count=1; without macro → done after third bit, bit_count=3.

Source files
------------

// File: rtl/comparador_serial_pkg.sv
// comparador_serial_pkg
//   Shared definitions for the bit-serial comparator: FSM state encoding,
//   select encodings and the default operand width.
package comparador_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SEL_IGUAL     = 1'b0;  // resultado = (A == B)
  localparam logic SEL_DIFERENTE = 1'b1;  // resultado = (A != B)

  localparam int DEFAULT_WIDTH = 3;

endpackage

// File: rtl/comparador_serial_deserializador.sv
// serial_deserializador
//   Reassembles one serial line into a parallel word. The incoming bit is
//   written at the position given by index (LSB first); all other bits hold.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset (word -> 0)
//     clear    synchronous clear of the whole word (new comparison)
//     shift_en write bit_in at position index this cycle
//     bit_in   serial data bit
//     index    destination bit position (only values < WIDTH are written)
//     word     reassembled word
module serial_deserializador #(
  parameter int WIDTH = 3,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [CW-1:0]    index,
  output logic [WIDTH-1:0] word
);

  // One flop per bit with its own decode, so an index outside the word
  // can never produce an out-of-range write.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word[gi] <= 1'b0;
      end else if (clear) begin
        word[gi] <= 1'b0;
      end else if (shift_en && (index == CW'(gi))) begin
        word[gi] <= bit_in;
      end
    end
  end

endmodule

// File: rtl/comparador_serial.sv
// comparador_serial
//   Bit-serial equality/difference comparator. Operands A and B arrive one
//   bit per cycle (LSB first); after WIDTH accepted bits the result is
//   published with a one-cycle done pulse.
//   Optional feature macro: COMP_EARLY_EXIT_EN -- when defined, the first
//   accepted bit pair that differs ends the comparison immediately.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start, sel          begin comparison / 0 = equality, 1 = difference
//     bit_valid           a_bit/b_bit valid this cycle
//     a_bit, b_bit        serial operand bits
//     busy                high in SHIFT and DONE
//     done                one-cycle pulse when resultado updates
//     resultado           comparison result, held until next done
//     a_word, b_word      reassembled operands
//     bit_count           bits accepted in the current comparison
module comparador_serial
  import comparador_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic             resultado,
  output logic [WIDTH-1:0] a_word,
  output logic [WIDTH-1:0] b_word,
  output logic [CW-1:0]    bit_count
);

  state_t state;
  logic   sel_q;
  logic   diff;

  logic accept;
  logic clear;
  logic diff_next;
  logic last_bit;
  logic finish;

  assign accept    = (state == SHIFT) && bit_valid;
  assign clear     = (state == IDLE) && start;
  assign diff_next = diff | (a_bit ^ b_bit);
  assign last_bit  = (bit_count == CW'(WIDTH - 1));

`ifdef COMP_EARLY_EXIT_EN
  // A differing bit pair already decides the outcome for either select.
  assign finish = last_bit || (a_bit ^ b_bit);
`else
  assign finish = last_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= SEL_IGUAL;
      diff      <= 1'b0;
      bit_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sel_q     <= sel;
            diff      <= 1'b0;
            bit_count <= '0;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            diff      <= diff_next;
            bit_count <= bit_count + 1'b1;
            if (finish) begin
              // Result is computed from diff_next so the final bit counts.
              resultado <= (sel_q == SEL_DIFERENTE) ? diff_next : ~diff_next;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  serial_deserializador #(.WIDTH(WIDTH), .CW(CW)) u_des_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (accept),
    .bit_in   (a_bit),
    .index    (bit_count),
    .word     (a_word)
  );

  serial_deserializador #(.WIDTH(WIDTH), .CW(CW)) u_des_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .shift_en (accept),
    .bit_in   (b_bit),
    .index    (bit_count),
    .word     (b_word)
  );

endmodule

// File: tb/tb_comparador_serial.sv
// tb_comparador_serial
//   Scoreboard bench for comparador_serial: the stimulus process pushes the
//   expected result of each comparison, a monitor pops and compares on done.
module tb_comparador_serial;

  localparam int W  = 3;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic bit_valid = 1'b0;
  logic a_bit = 1'b0;
  logic b_bit = 1'b0;

  logic          busy;
  logic          done;
  logic          resultado;
  logic [W-1:0]  a_word;
  logic [W-1:0]  b_word;
  logic [CW-1:0] bit_count;

  comparador_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sel       (sel),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .busy      (busy),
    .done      (done),
    .resultado (resultado),
    .a_word    (a_word),
    .b_word    (b_word),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         res;
    logic [W-1:0] aw;
    logic [W-1:0] bw;
    int           cnt;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resultado", 32'(resultado), 32'(e.res));
        check("a_word", 32'(a_word), 32'(e.aw));
        check("b_word", 32'(b_word), 32'(e.bw));
        check("bit_count", 32'(bit_count), 32'(e.cnt));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        $display("cmp: res=%0d a=%0h b=%0h cnt=%0d cycle=%0d", resultado, a_word, b_word, bit_count, cyc);
      end
    end
  end

  // Reference model: number of bits consumed, result and visible words.
  task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int n, output logic res,
                       output logic [W-1:0] aw, output logic [W-1:0] bw);
    logic [W-1:0] mask;
    n = W;
`ifdef COMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) if (a[i] != b[i]) n = i + 1;
`endif
    res  = s ? (a != b) : (a == b);
    mask = '0;
    for (int i = 0; i < n; i++) mask[i] = 1'b1;
    aw = a & mask;
    bw = b & mask;
  endtask

  task automatic run_cmp(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int gaps[W], input bit disturb);
    exp_t e;
    int   n;
    int   k;
    model(s, a, b, n, e.res, e.aw, e.bw);
    e.cnt = n;
    @(posedge clk); #1;
    start = 1'b1;
    sel   = s;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        bit_valid = 1'b0;
        @(posedge clk); #1;
      end
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      if (disturb && i == 0) begin
        start = 1'b1;
        sel   = ~s;
      end
      if (i == n - 1) begin
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk); #1;
      start     = 1'b0;
      bit_valid = 1'b0;
    end
    k = 0;
    while (busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("busy_released", 32'(busy), 32'd0);
    check("done_seen", 32'(sb.size()), 32'd0);
    sb.delete();
    check("a_word_hold", 32'(a_word), 32'(e.aw));
    $display("txn: sel=%0d A=%0h B=%0h gaps=%0d,%0d,%0d disturb=%0d", s, a, b,
             gaps[0], gaps[1], gaps[2], disturb);
  endtask

  task automatic reset_mid_shift();
    @(posedge clk); #1;
    start = 1'b1;
    sel   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'b1;
      b_bit     = 1'b1;
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'({busy, done, resultado, a_word, b_word, bit_count}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_after", 32'({busy, done, resultado, a_word, b_word, bit_count}), 32'd0);
    $display("txn: reset during SHIFT after 2 bits");
  endtask

  initial begin
    int g0[W];
    int gp[W];
    int rg[W];
    g0 = '{0, 0, 0};
    gp = '{0, 2, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({busy, done, resultado, a_word, b_word, bit_count}), 32'd0);
    rst_n = 1'b1;

    run_cmp(1'b0, 3'b101, 3'b101, g0, 1'b0);
    run_cmp(1'b1, 3'b001, 3'b010, g0, 1'b0);
    run_cmp(1'b0, 3'b001, 3'b010, g0, 1'b0);
    run_cmp(1'b0, 3'b110, 3'b110, gp, 1'b0);
    run_cmp(1'b1, 3'b000, 3'b001, g0, 1'b0);
    run_cmp(1'b0, 3'b011, 3'b011, g0, 1'b1);
    run_cmp(1'b1, 3'b011, 3'b111, gp, 1'b1);

    reset_mid_shift();
    run_cmp(1'b0, 3'b111, 3'b111, g0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : W'($urandom);
      foreach (rg[j]) rg[j] = $urandom_range(0, 2);
      run_cmp(1'($urandom), ra, rb, rg, 1'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
